// File: rtl/spi_adc_multi.sv
// Lockstep driver for NCH serial SPI ADCs sharing one chip-select.
// Frames are QUIET -> IDLE -> LEAD -> SHIFT -> TRAIL; results leave via a 4-phase handshake or a valid strobe.
module spi_adc_multi #(
  parameter int RES    = 8,
  parameter int NCH    = 1,
  parameter int LEAD   = 3,
  parameter int TRAIL  = 5,
  parameter int QUIET  = 4,
  parameter int INVERT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startCapture,
  input  logic                 freeRun,
  input  logic [NCH-1:0]       miso,
  output logic                 cs,
  output logic [NCH*RES-1:0]   dataout,
  output logic                 conversionComplete,
  output logic                 dataValid
);

  typedef enum logic [2:0] {ST_QUIET, ST_IDLE, ST_LEAD, ST_SHIFT, ST_TRAIL} state_t;

  localparam logic [3:0] LEAD_N  = 4'(LEAD);
  localparam logic [3:0] TRAIL_N = 4'(TRAIL);
  localparam logic [3:0] QUIET_N = 4'(QUIET);
  localparam logic [4:0] RES_N   = 5'(RES);
  localparam logic       INV_B   = (INVERT != 0);

  state_t                      state_r, state_s;
  logic [3:0]                  cnt_r, cnt_s;
  logic [4:0]                  bit_cnt_r, bit_cnt_s;
  logic                        single_r, single_s;
  logic                        cs_r, cs_s;
  logic                        valid_r, valid_s;
  logic                        cc_r, cc_s;
  logic [NCH-1:0][RES-1:0]     shreg_r, shreg_s;
  logic [NCH-1:0][RES-1:0]     dout_r, dout_s;
  logic [NCH-1:0]              bits_s;

  function automatic logic [RES-1:0] shift_in(input logic [RES-1:0] v, input logic b);
    logic [RES:0] ext;
    ext = {v, b};
    return ext[RES-1:0];
  endfunction

  assign bits_s = miso ^ {NCH{INV_B}};

  // Next-state and next-output logic for the framing FSM and handshake.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_cnt_s = bit_cnt_r;
    single_s  = single_r;
    cs_s      = cs_r;
    valid_s   = 1'b0;
    shreg_s   = shreg_r;
    dout_s    = dout_r;
    // Ack first; a completion set below overrides it when both apply.
    if (!cc_r && startCapture) begin
      cc_s = 1'b1;
    end else begin
      cc_s = cc_r;
    end
    case (state_r)
      ST_QUIET: begin
        if (cnt_r <= 4'd1) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_IDLE: begin
        if (freeRun || (!startCapture && cc_r)) begin
          single_s = ~freeRun;
          cs_s     = 1'b0;
          if (LEAD_N == 4'd0) begin
            state_s   = ST_SHIFT;
            bit_cnt_s = RES_N;
          end else begin
            state_s = ST_LEAD;
            cnt_s   = LEAD_N;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (cnt_r <= 4'd1) begin
          state_s   = ST_SHIFT;
          bit_cnt_s = RES_N;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_SHIFT: begin
        for (int i = 0; i < NCH; i++) begin
          shreg_s[i] = shift_in(shreg_r[i], bits_s[i]);
        end
        if (bit_cnt_r <= 5'd1) begin
          state_s = ST_TRAIL;
          cnt_s   = TRAIL_N;
          valid_s = 1'b1;
          dout_s  = shreg_s;
          if (single_r) begin
            cc_s = 1'b0;
          end else begin
            cc_s = cc_s;
          end
        end else begin
          bit_cnt_s = bit_cnt_r - 5'd1;
        end
      end
      ST_TRAIL: begin
        if (cnt_r <= 4'd1) begin
          state_s = ST_QUIET;
          cnt_s   = QUIET_N;
          cs_s    = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_QUIET;
        cnt_s   = QUIET_N;
        cs_s    = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_QUIET;
      cnt_r     <= QUIET_N;
      bit_cnt_r <= 5'd0;
      single_r  <= 1'b0;
      cs_r      <= 1'b1;
      valid_r   <= 1'b0;
      cc_r      <= 1'b1;
      shreg_r   <= '0;
      dout_r    <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_cnt_r <= bit_cnt_s;
      single_r  <= single_s;
      cs_r      <= cs_s;
      valid_r   <= valid_s;
      cc_r      <= cc_s;
      shreg_r   <= shreg_s;
      dout_r    <= dout_s;
    end
  end

  assign cs                 = cs_r;
  assign dataout            = dout_r;
  assign conversionComplete = cc_r;
  assign dataValid          = valid_r;

endmodule

// File: doc/spi_adc_multi.md
# spi_adc_multi

Parametrised driver for serial-output SPI ADCs (ADC081S101 family and wider-resolution siblings), reading `NCH` converters in lockstep that share one chip-select and one externally generated SCLK derived from `clk`. It frames each conversion with programmable leading, trailing and quiet intervals and shifts in `RES` bits per channel. Results go to the fabric through either a single-shot four-phase handshake or a free-running mode with a one-cycle valid strobe. It sits between the sensor-board ADC pins and the capture/DMA logic.

## Interface
Parameters:
- `RES`, 8: bits per conversion per channel, 1..16.
- `NCH`, 1: number of parallel MISO lines, 1..8.
- `LEAD`, 3: cycles with cs low before the first data bit, 0..15.
- `TRAIL`, 5: cycles with cs low after the last data bit, 1..15.
- `QUIET`, 4: minimum cycles with cs high between frames, 1..15.
- `INVERT`, 1: 1 means each sampled bit is stored inverted (board has inverting buffers).

Ports:
- `clk` input 1: system clock; SCLK is `clk` supplied externally; miso is sampled on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `startCapture` input 1: active-low capture request (single-shot mode).
- `freeRun` input 1: 1 selects continuous conversions; sampled only in IDLE.
- `miso` input NCH: serial data, bit i from ADC i.
- `cs` output 1: shared chip-select, active low.
- `dataout` output NCH*RES: channel i in bits [i*RES +: RES], MSB first on the wire.
- `conversionComplete` output 1: active-low completion (single-shot mode).
- `dataValid` output 1: one-cycle high pulse when `dataout` updates (both modes).

## Operation
- States: QUIET, IDLE, LEAD, SHIFT, TRAIL; one down-counter (4 bits) and a bit counter (5 bits).
- Reset values: QUIET with counter=QUIET, `cs`=1, `dataout`=0, `conversionComplete`=1, `dataValid`=0, shift registers=0.
- QUIET: `cs`=1; decrements; after QUIET cycles → IDLE.
- IDLE: `cs`=1. If `freeRun`=1, or (`startCapture`=0 and `conversionComplete`=1), go to LEAD (or to SHIFT if LEAD=0) and drive `cs`=0 on the next cycle. Otherwise stay in IDLE.
- LEAD: `cs`=0 for LEAD cycles, then → SHIFT.
- SHIFT: `cs`=0 for RES cycles. Each cycle, every channel shift register shifts left and takes in `miso[i]^INVERT`. The first sampled bit ends up as the MSB.
- SHIFT → TRAIL transition:
  - all shift registers are copied into `dataout` at once;
  - `dataValid`=1 for exactly that one cycle;
  - if the frame was started in single-shot mode, `conversionComplete`←0.
- TRAIL: `cs`=0 for TRAIL cycles, then `cs`←1, counter←QUIET → QUIET.
- Ack rule (any state): if `conversionComplete`=0 and `startCapture`=1, then `conversionComplete`←1 next cycle. No new single-shot frame can start while `conversionComplete`=0, which gives a full four-phase handshake.
- If `startCapture` is still 0 when `conversionComplete` would be set, the set has priority; the ack waits for the release.
- `startCapture` is ignored in free-run mode for starting frames, but it still clears a pending `conversionComplete`.
- Mode changes take effect only at IDLE; a frame in flight always completes under the mode it started in.
- Asynchronous reset mid-frame: `cs` goes to 1 immediately, partial data is discarded, `dataout` is cleared.

## Timing
- `cs` low duration is exactly LEAD+RES+TRAIL cycles.
- `cs` high between frames is at least QUIET+1 cycles (QUIET, plus at least one IDLE cycle).
- Free-run frame period is LEAD+RES+TRAIL+QUIET+1 cycles (defaults: 21).
- Single-shot latency:
  - `startCapture` sampled low in IDLE at cycle t → `cs`=0 at t+1;
  - `dataValid`/`conversionComplete` change at t+1+LEAD+RES;
  - `cs`=1 at t+1+LEAD+RES+TRAIL.
- `dataout` is stable from the `dataValid` cycle until the next `dataValid`.

## Test plan
- Reset release, defaults, NCH=2, `startCapture` held 0, miso0 bits 1,0,1,1,0,0,1,0 and miso1 constant 0:
  - `cs` falls 5 cycles after reset release (4 quiet + 1 idle), low for 16 cycles;
  - `dataout`={8'hFF, 8'h4D};
  - `conversionComplete` falls together with the `dataValid` pulse.
- Handshake: hold `startCapture`=0 for 40 cycles after completion → exactly one frame. Release it → `conversionComplete`=1 next cycle. Assert it again → new frame only after QUIET has elapsed.
- Free-run, INVERT=0, miso0 alternating per bit starting with 1 → `dataout`=8'hAA every 21 cycles; `dataValid` is high exactly 1 cycle per frame; `conversionComplete` stays 1.
- Mode switch: set `freeRun`=0 mid-SHIFT → current frame completes normally, no further frames start without `startCapture`.
- Reset asserted mid-SHIFT → same cycle `cs`=1, `dataout`=0, `dataValid`=0. After release, the first `cs` fall comes only after QUIET+1 cycles.
- LEAD=0, RES=12, TRAIL=1, QUIET=1 → `cs` low exactly 13 cycles, 12-bit result is correct, free-run period is 15 cycles.
